freq_div_2: RTL and testbench

- Synchronous divide-by-2 clock/frequency divider.
- Primary output `out` toggles on every enabled rising edge of `clk`, giving a square wave at half the clock frequency with 50% duty.
- Optional cascade of further divide-by-2 stages (/4, /8, …) with one-cycle rise strobes, for use as a slow-tick generator feeding counters and timing logic.

---
 rtl/freq_div_pkg.sv | 7 +
 rtl/div2_stage.sv | 44 ++++
 rtl/freq_div_2.sv | 50 +++++
 tb/tb_freq_div_2.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants for the freq_div_2 divider family.
//   FREQ_DIV_DEFAULT_STAGES : stage count used when the parent does not override STAGES
//   FREQ_DIV_MAX_STAGES     : largest supported cascade depth
package freq_div_pkg;
  localparam int FREQ_DIV_DEFAULT_STAGES = 1;
  localparam int FREQ_DIV_MAX_STAGES     = 16;
endpackage

// File: rtl/div2_stage.sv
// One divide-by-2 cell: a T flip-flop with a registered rise strobe.
// Ports:
//   clk  : system clock, rising edge
//   rst  : async active-high reset, clears q and rise
//   clr  : sync clear, overrides tgl
//   tgl  : toggle enable for this edge
//   q    : stage output
//   rise : high for the one cycle following a 0->1 transition of q
module div2_stage (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tgl,
  output logic q,
  output logic rise
);
  logic q_q, q_d;
  logic rise_q, rise_d;

  always_comb begin
    q_d    = q_q;
    rise_d = 1'b0;
    if (clr) begin
      q_d = 1'b0;
    end else if (tgl) begin
      q_d    = ~q_q;
      // Only a toggle from 0 is a rise; a 1->0 toggle (wrap) strobes nothing.
      rise_d = ~q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
endmodule

// File: rtl/freq_div_2.sv
// Divide-by-2 clock divider with an optional ripple-free cascade of /2 stages.
// The cascade behaves as a STAGES-bit synchronous binary up-counter; bit k
// runs at clk/2^(k+1) with 50% duty while en is held.
// Ports:
//   clk     : system clock
//   rst     : async active-high reset
//   en      : count enable; all stages hold when low
//   clr     : sync clear, takes priority over en
//   out     : clk/2 square wave (out_vec[0])
//   out_vec : divided outputs, bit k = clk/2^(k+1)
//   tick    : one-cycle strobe after out_vec[k] rose
module freq_div_2
  import freq_div_pkg::*;
#(
  parameter int STAGES = FREQ_DIV_DEFAULT_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic              out,
  output logic [STAGES-1:0] out_vec,
  output logic [STAGES-1:0] tick
);
  if (STAGES < 1 || STAGES > FREQ_DIV_MAX_STAGES) begin : g_bad_stages
    $error("freq_div_2: STAGES=%0d outside 1..%0d", STAGES, FREQ_DIV_MAX_STAGES);
  end

  // carry[k]: stage k toggles this edge (en AND all lower stages at 1).
  logic [STAGES-1:0] carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_c0
      assign carry[k] = en;
    end else begin : g_cn
      assign carry[k] = carry[k-1] & out_vec[k-1];
    end

    div2_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tgl  (carry[k]),
      .q    (out_vec[k]),
      .rise (tick[k])
    );
  end

  assign out = out_vec[0];
endmodule

// File: tb/tb_freq_div_2.sv
module tb_freq_div_2;
  localparam int N = 4;

  logic clk = 1'b1;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic         out;
  logic [N-1:0] out_vec;
  logic [N-1:0] tick;

  freq_div_2 #(.STAGES(N)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .out(out), .out_vec(out_vec), .tick(tick)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: an integer count modulo 2^N; tick = bits that went 0->1.
  int           m_cnt  = 0;
  logic [N-1:0] m_tick = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, ".vec"},  int'(out_vec), m_cnt);
    chk({name, ".tick"}, int'(tick),    int'(m_tick));
    chk({name, ".out"},  int'(out),     m_cnt % 2);
  endtask

  // Apply inputs, take one rising edge, advance model, check mid-cycle.
  task automatic cyc(input logic e, input logic c, input string name);
    int old;
    en  = e;
    clr = c;
    @(posedge clk);
    old = m_cnt;
    if (rst || c) begin
      m_cnt = 0; m_tick = '0;
    end else if (e) begin
      m_cnt  = (m_cnt + 1) % (1 << N);
      m_tick = N'(m_cnt) & ~N'(old);
    end else begin
      m_tick = '0;
    end
    #5;
    chk_model(name);
  endtask

  task automatic goto_val(input int v);
    cyc(1'b0, 1'b1, "goto.clr");
    for (int i = 0; i < v; i++) cyc(1'b1, 1'b0, "goto.cnt");
  endtask

  typedef struct {
    logic         en;
    logic         clr;
    logic [N-1:0] exp_vec;
    logic [N-1:0] exp_tick;
  } vec_t;

  vec_t vt[10];
  int   t3_pulses;

  initial begin
    // Hand-computed table, starting from count 0.
    vt[0] = '{1'b1, 1'b0, 4'd1, 4'b0001};
    vt[1] = '{1'b1, 1'b0, 4'd2, 4'b0010};
    vt[2] = '{1'b0, 1'b0, 4'd2, 4'b0000};
    vt[3] = '{1'b1, 1'b0, 4'd3, 4'b0001};
    vt[4] = '{1'b1, 1'b0, 4'd4, 4'b0100};
    vt[5] = '{1'b1, 1'b1, 4'd0, 4'b0000};
    vt[6] = '{1'b1, 1'b0, 4'd1, 4'b0001};
    vt[7] = '{1'b0, 1'b1, 4'd0, 4'b0000};
    vt[8] = '{1'b0, 1'b0, 4'd0, 4'b0000};
    vt[9] = '{1'b1, 1'b0, 4'd1, 4'b0001};

    // Reset held 25 ns from t=0 (clk starts high).
    #5;  chk("rst.vec5", int'(out_vec), 0); chk("rst.tick5", int'(tick), 0);
    #17; chk("rst.vec22", int'(out_vec), 0); chk("rst.out22", int'(out), 0);
    #3;  rst = 1'b0; en = 1'b1;
    // First enabled edge after release (t=40) sets out=1, then toggles.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, "rel");

    // Table-driven vectors.
    goto_val(0);
    foreach (vt[i]) begin
      en = vt[i].en; clr = vt[i].clr;
      @(posedge clk); #5;
      chk($sformatf("tbl%0d.vec", i),  int'(out_vec), int'(vt[i].exp_vec));
      chk($sformatf("tbl%0d.tick", i), int'(tick),    int'(vt[i].exp_tick));
    end
    m_cnt = int'(out_vec); m_tick = tick;

    // Free run 400 cycles from 0: exactly 25 tick[3] pulses.
    goto_val(0);
    t3_pulses = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'b0, "free");
      if (tick[3]) t3_pulses++;
    end
    chk("free.t3_pulses", t3_pulses, 25);

    // Enable gating at 0101.
    goto_val(5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "gate.hold");
    cyc(1'b1, 1'b0, "gate.resume");
    chk("gate.vec6", int'(out_vec), 6);
    chk("gate.tick1", int'(tick), 2);

    // Sync clear at 1011 beats en.
    goto_val(11);
    cyc(1'b1, 1'b1, "clr.hit");
    chk("clr.vec0", int'(out_vec), 0);
    cyc(1'b1, 1'b0, "clr.r1");
    cyc(1'b1, 1'b0, "clr.r2");
    chk("clr.vec2", int'(out_vec), 2);

    // Async reset between edges at 0111.
    goto_val(7);
    @(negedge clk);
    rst = 1'b1; m_cnt = 0; m_tick = '0;
    #1;
    chk("arst.vec", int'(out_vec), 0);
    chk("arst.tick", int'(tick), 0);
    #2; rst = 1'b0;
    cyc(1'b1, 1'b0, "arst.first");
    chk("arst.vec1", int'(out_vec), 1);
    chk("arst.tick0", int'(tick), 1);

    // rst, clr, en all high: stay 0.
    goto_val(3);
    @(negedge clk);
    rst = 1'b1; m_cnt = 0; m_tick = '0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, "all_hi");
    @(negedge clk); rst = 1'b0;

    // Randomized stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        rst = 1'b1; m_cnt = 0; m_tick = '0;
        #1; chk_model("rnd.arst");
        #2; rst = 1'b0;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
